fract_divider: RTL

- Sequential restoring divider for normalised 7-bit fractions with hidden bit. Computes (1.a_fract) / (1.b_fract).
- Datapath counterpart to the fraction adder used in the multiplier path. It is the mantissa stage of the float divide path.
- Produces one quotient bit per cycle, then outputs:
  - a normalised fraction,
  - guard bits and a sticky bit for the downstream rounder,
  - an exponent-decrement flag for the exponent logic.

---
 rtl/fract_pkg.sv | 14 +
 rtl/fract_divider_if.sv | 28 ++
 rtl/fract_subtractor.sv | 27 ++
 rtl/full_adder.sv | 13 +
 rtl/fract_divider.sv | 123 ++++++++++++
 5 files changed

// File: rtl/fract_pkg.sv
// Shared definitions for the normalised-fraction divider: default widths and
// controller state encoding.
package fract_pkg;

   localparam int unsigned FRAC_W_DEF  = 7;
   localparam int unsigned GUARD_W_DEF = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_e;

endpackage : fract_pkg

// File: rtl/fract_divider_if.sv
// Operand/result handshake bundle between the divider and its producer/consumer.
interface fract_divider_if #(
   parameter int unsigned FRAC_W  = fract_pkg::FRAC_W_DEF,
   parameter int unsigned GUARD_W = fract_pkg::GUARD_W_DEF
) ();

   logic               in_valid;
   logic               in_ready;
   logic [FRAC_W-1:0]  a_fract;
   logic [FRAC_W-1:0]  b_fract;
   logic               out_valid;
   logic               out_ready;
   logic [FRAC_W-1:0]  q_fract;
   logic [GUARD_W-1:0] q_guard;
   logic               q_sticky;
   logic               exp_dec;

   modport master (
      output in_valid, a_fract, b_fract, out_ready,
      input  in_ready, out_valid, q_fract, q_guard, q_sticky, exp_dec
   );

   modport slave (
      input  in_valid, a_fract, b_fract, out_ready,
      output in_ready, out_valid, q_fract, q_guard, q_sticky, exp_dec
   );

endinterface : fract_divider_if

// File: rtl/fract_subtractor.sv
// Ripple subtractor a - b computed as a + ~b + 1; borrow_n=1 means a >= b.
module fract_subtractor #(
   parameter int unsigned W = 9
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         borrow_n
);

   logic [W:0] carry;

   assign carry[0] = 1'b1;

   for (genvar g = 0; g < W; g++) begin : g_bit
      full_adder u_fa (
         .a    (a[g]),
         .b    (~b[g]),
         .cin  (carry[g]),
         .sum  (diff[g]),
         .cout (carry[g+1])
      );
   end

   assign borrow_n = carry[W];

endmodule : fract_subtractor

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/fract_divider.sv
// Sequential restoring divider for (1.a)/(1.b): one quotient bit per cycle,
// normalised fraction, guard/sticky bits and exponent-decrement flag out.
module fract_divider
   import fract_pkg::*;
#(
   parameter int unsigned FRAC_W  = FRAC_W_DEF,
   parameter int unsigned GUARD_W = GUARD_W_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   fract_divider_if.slave  bus
);

   localparam int unsigned R_W   = FRAC_W + 2;
   localparam int unsigned Q_W   = FRAC_W + 1 + GUARD_W;
   localparam int unsigned CNT_W = $clog2(Q_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Q_W - 1);

   div_state_e       state_q, state_d;
   logic [R_W-1:0]   r_q, r_d;
   logic [R_W-1:0]   d_q, d_d;
   logic [Q_W-1:0]   q_q, q_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;

   logic [R_W-1:0]   diff;
   logic             borrow_n;

   fract_subtractor #(.W(R_W)) u_sub (
      .a        (r_q),
      .b        (d_q),
      .diff     (diff),
      .borrow_n (borrow_n)
   );

   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      d_d         = d_q;
      q_d         = q_q;
      cnt_d       = cnt_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               r_d        = {2'b01, bus.a_fract};
               d_d        = {2'b01, bus.b_fract};
               q_d        = '0;
               cnt_d      = '0;
               in_ready_d = 1'b0;
               state_d    = CALC;
            end
         end
         CALC: begin
            // R < 2D keeps both shifted candidates inside R_W bits.
            q_d   = {q_q[Q_W-2:0], borrow_n};
            r_d   = borrow_n ? (diff << 1) : (r_q << 1);
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         r_q         <= '0;
         d_q         <= '0;
         q_q         <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         d_q         <= d_d;
         q_q         <= q_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;

   // Quotient in [0.5,2): top bit clear means one extra shift and an exponent decrement.
   always_comb begin
      bus.q_fract  = '0;
      bus.q_guard  = '0;
      bus.q_sticky = 1'b0;
      bus.exp_dec  = 1'b0;
      if (state_q == DONE) begin
         if (q_q[Q_W-1]) begin
            bus.q_fract = q_q[Q_W-2 -: FRAC_W];
            bus.q_guard = q_q[GUARD_W-1:0];
         end else begin
            bus.q_fract = q_q[Q_W-3 -: FRAC_W];
            bus.q_guard = GUARD_W'({q_q[GUARD_W-1:0], 1'b0});
            bus.exp_dec = 1'b1;
         end
         bus.q_sticky = |r_q;
      end
   end

endmodule : fract_divider
